tm1638_serial_tx: RTL
=====================

// Module: tm1638_serial_tx
// PURPOSE
//  Byte-level serial engine driving TM1638 pins STB/CLK/DIO. Sits directly downstream of the
//  TM1638 display controller: that block sequences commands and segment bytes for F/S/T; this
//  block frames them (STB low), shifts each byte LSB-first on DIO and returns key-scan data.
// PARAMETERS
//  CLK_DIV   25  sys-clk cycles per half period of the serial clock (one CLK phase); >=2
//  RD_BYTES  4   key-scan bytes clocked in after a read command (optional feature only)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst       in   1  asynchronous, active-low reset
//  tx_data   in   8  byte to send, transmitted bit0 first
//  tx_valid  in   1  tx_data/tx_last/tx_rd valid
//  tx_last   in   1  byte closes the frame (STB released after it)
//  tx_rd     in   1  byte is a read command; key-scan bytes follow (optional feature)
//  tx_ready  out  1  byte accepted on a clk where tx_valid&tx_ready
//  busy      out  1  frame in progress (STB low or STB recovery gap)
//  out_clk   out  1  TM1638 CLK, idles high
//  strobe    out  1  TM1638 STB, active-low frame enable
//  dio_o     out  1  DIO drive value
//  dio_oe    out  1  1 = drive DIO, 0 = release (pad tristate)
//  dio_i     in   1  DIO pad input
//  rx_data   out  8  received key-scan byte, bit0 first on wire
//  rx_valid  out  1  one-cycle pulse, rx_data valid
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE, out_clk=1, strobe=1, dio_o=1, dio_oe=1, rx_valid=0,
//    rx_data=0, busy=0, counters 0. Reset mid-frame aborts instantly; pins return to idle levels.
//  - tx_ready = (state==IDLE)|(state==NEXT), combinational; 1 out of reset.
//  - Phase tick: internal counter 0..CLK_DIV-1; every state advance below occurs on tick.
//  - IDLE: on accept, strobe<=0, shift reg<=tx_data, dio_o<=tx_data[0], latch last/rd -> SETUP.
//  - SETUP: hold 1 phase (CLK_DIV cycles) with out_clk=1 -> SHIFT.
//  - SHIFT: per bit: out_clk=0 for 1 phase (dio_o updates at the falling edge), out_clk=1 for
//    1 phase; TM1638 samples on rising edge. 8 bits = 16*CLK_DIV cycles.
//  - After bit7 high phase: rd -> READ; last -> HOLD; else NEXT.
//  - NEXT: out_clk=1, strobe=0, waits indefinitely for tx_valid; accept -> SHIFT (bit0 driven).
//  - HOLD: strobe stays 0 for 1 phase, then strobe<=1 -> GAP.
//  - GAP: strobe=1, out_clk=1 for 2 phases (STB min-high), busy=1 -> IDLE.
//  - tx_valid while tx_ready=0 is ignored (no capture); tx_data may change freely then.
//  - tx_last and tx_rd both set: read takes precedence, frame ends after the read.
//  - Byte-to-byte latency with tx_valid held high: zero idle phases between bytes.
// CONFIGURATION
//  - TM1638_KEY_READ_EN defined: READ state: dio_oe<=0 at end of command byte, wait 2 phases,
//    then RD_BYTES*8 clock pulses; dio_i sampled on the sys-clk of each rising out_clk edge,
//    bit0 first; rx_valid pulses once per completed byte, the cycle after its bit7 sample;
//    then dio_oe<=1, dio_o<=1 -> HOLD.
//  - Not defined: no READ state; tx_rd and dio_i ignored; dio_oe tied 1; rx_valid=0, rx_data=0.
// STRUCTURE
//  - tm1638_pkg: state enum (IDLE, SETUP, SHIFT, NEXT, READ, HOLD, GAP); command constants
//    CMD_WR_AUTO=8'h40, CMD_WR_FIXED=8'h44, CMD_RD_KEYS=8'h42, CMD_ADDR0=8'hC0, CMD_DISP_ON=8'h88.
//  - Sub-module tm1638_tick_gen: CLK_DIV phase counter, tick output, cleared on frame start.
// TESTING
//  - CLK_DIV=4, send 8'h40 with tx_last: STB low 18 phases total; DIO 0,0,0,0,0,0,1,0 at
//    rising edges; STB high, busy low after GAP (2 phases).
//  - 8'hC0, 8'h3F(last) back-to-back, tx_valid held: one STB-low window, 16 contiguous
//    CLK pulses, no idle phase between bytes; decoded bytes C0,3F.
//  - Stall: 8'hC0 then tx_valid=0 for 100 cycles: out_clk=1, strobe=0, tx_ready=1 throughout;
//    8'h06(last) then completes frame correctly.
//  - rst asserted mid-SHIFT of 8'hA5: same cycle out_clk=1, strobe=1, dio_oe=1; next accepted
//    byte starts a fresh frame from bit0.
//  - TM1638_KEY_READ_EN, 8'h42 with tx_rd, pad model returns 01,02,04,80: dio_oe=0 during
//    read, 4 rx_valid pulses with exactly those values, then STB high.
//  - tx_valid pulsed during SHIFT: no capture, transmitted byte unchanged, tx_ready stays 0.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 serial engine: FSM state encoding and
// the TM1638 command bytes used by the upstream display controller.
package tm1638_pkg;

    // Serial engine states. READ is only reachable when TM1638_KEY_READ_EN is defined.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        NEXT  = 3'd3,
        READ  = 3'd4,
        HOLD  = 3'd5,
        GAP   = 3'd6
    } tm_state_e;

    // TM1638 command bytes
    localparam logic [7:0] CMD_WR_AUTO  = 8'h40;
    localparam logic [7:0] CMD_WR_FIXED = 8'h44;
    localparam logic [7:0] CMD_RD_KEYS  = 8'h42;
    localparam logic [7:0] CMD_ADDR0    = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON  = 8'h88;

endpackage : tm1638_pkg

// File: rtl/tm1638_tick_gen.sv
// Phase timer for the TM1638 serial engine. Counts CLK_DIV system clocks per
// serial-clock phase and raises tick_o on the last cycle of each phase. While
// clear_i is high the count is held at zero so that the first phase after a
// byte is accepted is a full CLK_DIV cycles long.
module tm1638_tick_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: held at zero while cleared, wraps after the last cycle of a phase
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Phase counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clear_i && (cnt_q == LAST);

endmodule : tm1638_tick_gen

// File: rtl/tm1638_serial_tx.sv
// Byte-level serial engine for the TM1638 STB/CLK/DIO interface. Frames bytes
// with STB low, shifts them LSB-first on DIO (changing on the falling CLK edge,
// sampled by the TM1638 on the rising edge) and enforces the STB high gap.
// Optional key-scan read path is compiled in with `define TM1638_KEY_READ_EN;
// without it tx_rd and dio_i are ignored, dio_oe is tied high and rx_* are zero.
module tm1638_serial_tx
    import tm1638_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 25,
    parameter int unsigned RD_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    input  logic       tx_rd,
    output logic       tx_ready,
    output logic       busy,
    output logic       out_clk,
    output logic       strobe,
    output logic       dio_o,
    output logic       dio_oe,
    input  logic       dio_i,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    tm_state_e  state_q;
    logic       last_q;
    logic [7:0] sh_q;
    logic [2:0] bit_q;
    logic       hi_q;
    logic       out_clk_q;
    logic       strobe_q;
    logic       dio_o_q;
    logic       tick;
    logic       accept;

`ifdef TM1638_KEY_READ_EN
    localparam int unsigned BYTE_W = (RD_BYTES > 1) ? $clog2(RD_BYTES) : 1;

    logic              rd_q;
    logic              rwait_q;
    logic [BYTE_W-1:0] byte_q;
    logic              dio_oe_q;
    logic [7:0]        rx_sh_q;
    logic [7:0]        rx_data_q;
    logic              rx_valid_q;
`endif

    assign tx_ready = (state_q == IDLE) || (state_q == NEXT);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_q != IDLE);

    // The phase timer is parked at zero while waiting for a byte, so a byte
    // accepted in NEXT starts its bit0 low phase immediately with no idle phase.
    tm1638_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tx_ready),
        .tick_o  (tick)
    );

    // Framing / shifting FSM with registered pin outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b0;
            sh_q       <= '0;
            bit_q      <= '0;
            hi_q       <= 1'b0;
            out_clk_q  <= 1'b1;
            strobe_q   <= 1'b1;
            dio_o_q    <= 1'b1;
`ifdef TM1638_KEY_READ_EN
            rd_q       <= 1'b0;
            rwait_q    <= 1'b0;
            byte_q     <= '0;
            dio_oe_q   <= 1'b1;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`endif
        end else begin
`ifdef TM1638_KEY_READ_EN
            rx_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        strobe_q <= 1'b0;
                        sh_q     <= tx_data;
                        dio_o_q  <= tx_data[0];
                        last_q   <= tx_last;
`ifdef TM1638_KEY_READ_EN
                        rd_q     <= tx_rd;
`endif
                        bit_q    <= '0;
                        hi_q     <= 1'b0;
                        state_q  <= SETUP;
                    end
                end

                SETUP: begin
                    if (tick) begin
                        out_clk_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (tick) begin
                        if (!hi_q) begin
                            out_clk_q <= 1'b1;
                            hi_q      <= 1'b1;
                        end else if (bit_q != 3'd7) begin
                            bit_q     <= bit_q + 3'd1;
                            hi_q      <= 1'b0;
                            out_clk_q <= 1'b0;
                            dio_o_q   <= sh_q[bit_q + 3'd1];
                        end else begin
                            hi_q  <= 1'b0;
                            bit_q <= '0;
`ifdef TM1638_KEY_READ_EN
                            // A read command wins over tx_last; HOLD follows the read.
                            if (rd_q) begin
                                dio_oe_q <= 1'b0;
                                rwait_q  <= 1'b1;
                                byte_q   <= '0;
                                state_q  <= READ;
                            end else
`endif
                            if (last_q) begin
                                state_q <= HOLD;
                            end else begin
                                state_q <= NEXT;
                            end
                        end
                    end
                end

                NEXT: begin
                    if (accept) begin
                        sh_q      <= tx_data;
                        dio_o_q   <= tx_data[0];
                        last_q    <= tx_last;
`ifdef TM1638_KEY_READ_EN
                        rd_q      <= tx_rd;
`endif
                        bit_q     <= '0;
                        hi_q      <= 1'b0;
                        out_clk_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end

`ifdef TM1638_KEY_READ_EN
                READ: begin
                    if (tick) begin
                        if (rwait_q) begin
                            // Two high phases of turnaround before the first read pulse
                            if (hi_q) begin
                                rwait_q   <= 1'b0;
                                hi_q      <= 1'b0;
                                out_clk_q <= 1'b0;
                            end else begin
                                hi_q <= 1'b1;
                            end
                        end else if (!hi_q) begin
                            out_clk_q <= 1'b1;
                            hi_q      <= 1'b1;
                            rx_sh_q   <= {dio_i, rx_sh_q[7:1]};
                            if (bit_q == 3'd7) begin
                                rx_data_q  <= {dio_i, rx_sh_q[7:1]};
                                rx_valid_q <= 1'b1;
                            end
                        end else begin
                            hi_q <= 1'b0;
                            if (bit_q != 3'd7) begin
                                bit_q     <= bit_q + 3'd1;
                                out_clk_q <= 1'b0;
                            end else begin
                                bit_q <= '0;
                                if (byte_q == BYTE_W'(RD_BYTES - 1)) begin
                                    dio_oe_q <= 1'b1;
                                    dio_o_q  <= 1'b1;
                                    state_q  <= HOLD;
                                end else begin
                                    byte_q    <= byte_q + BYTE_W'(1);
                                    out_clk_q <= 1'b0;
                                end
                            end
                        end
                    end
                end
`endif

                HOLD: begin
                    if (tick) begin
                        strobe_q <= 1'b1;
                        dio_o_q  <= 1'b1;
                        hi_q     <= 1'b0;
                        state_q  <= GAP;
                    end
                end

                GAP: begin
                    if (tick) begin
                        if (hi_q) begin
                            hi_q    <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            hi_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    out_clk_q <= 1'b1;
                    strobe_q  <= 1'b1;
                    dio_o_q   <= 1'b1;
                end
            endcase
        end
    end

    assign out_clk = out_clk_q;
    assign strobe  = strobe_q;
    assign dio_o   = dio_o_q;

`ifdef TM1638_KEY_READ_EN
    assign dio_oe   = dio_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    logic unused_read_path;
    assign unused_read_path = ^{tx_rd, dio_i, RD_BYTES[0]};

    assign dio_oe   = 1'b1;
    assign rx_data  = '0;
    assign rx_valid = 1'b0;
`endif

endmodule : tm1638_serial_tx
